// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// decode-side instruction handshake. The fetch stage is the master.
interface fetch_queue_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [ILEN-1:0] imem_rdata_i;
  logic            instr_valid_o;
  logic [ILEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;
  logic            instr_ready_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rdata_i,
    output instr_valid_o,
    output instr_o,
    output pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rdata_i,
    input  instr_valid_o,
    input  instr_o,
    input  pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues one-cycle-latency memory reads and
// buffers {instr, pc} in a DEPTH-entry FIFO. Optional macro: FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  fetch_queue_if.master   bus
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_bubbles_o
`endif
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam int              CNT_W      = PTR_W + 1;
  localparam int              IBYTES     = ILEN / 8;
  localparam int              ALIGN_W    = $clog2(IBYTES);
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(IBYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_W) - XLEN'(1));
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  inflight_pc_q;
  logic             inflight_q;
  logic [ILEN-1:0]  instr_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [CNT_W-1:0] occupancy;
  logic             req;
  logic             head_valid;
  logic             push;
  logic             pop;

  // Decode handshake: an instruction transfers in a cycle where instr_valid_o
  // and instr_ready_i are both high, unless stall_i or redirect_i suppresses the
  // pop. instr_valid_o never depends on instr_ready_i, and once raised it stays
  // high with a stable head until the transfer or a redirect/reset.
  always_comb begin
    occupancy  = count_q + CNT_W'(inflight_q);
    // The in-flight word already owns a slot, so a request can never overflow.
    req        = rst_n && !stall_i && !redirect_i && (occupancy < DEPTH_CNT);
    head_valid = (count_q != '0);
    push       = inflight_q && !redirect_i;
    pop        = head_valid && bus.instr_ready_i && !stall_i && !redirect_i;
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = head_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.pc_o          = head_valid ? pc_mem_q[rd_ptr_q]    : '0;

  // Redirect outranks everything: the arriving response is dropped with the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else if (redirect_i) begin
      pc_q       <= redirect_pc_i & ALIGN_MASK;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= req;
      if (req) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + PC_INC;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Bubble = an unstalled cycle with nothing for decode; saturates rather than wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubbles_o <= '0;
    end else if (!head_valid && !stall_i && (perf_bubbles_o != 32'hFFFF_FFFF)) begin
      perf_bubbles_o <= perf_bubbles_o + 32'd1;
    end
  end
`endif

endmodule
